// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the sequential ALU.
//   alu_op_e : 3-bit opcode encoding carried on alu_control
//   FLAG_*   : bit positions inside the 4-bit flags vector
//   state_e  : control state of alu_seq (IDLE / iterating MUL)
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_LSL = 3'b101,
        OP_LSR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
// Unsigned shift-add multiplier, one partial product per cycle, WIDTH steps.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture a/b and clear the accumulator
//   run        : perform one shift-add step this cycle
//   a, b       : operands (WIDTH bits)
//   product    : accumulator value including the step of the current cycle
//   last       : the step of the current cycle is the final one
// ---------------------------------------------------------------------------
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               run,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplr;
    logic [CW-1:0]      count;

    // Exposing the post-step sum lets the parent register the final product
    // on the same edge as the last step, without an extra cycle.
    assign product = acc + (mplr[0] ? mcand : '0);
    assign last    = (count == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            count <= '0;
        end else if (load) begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, a};
            mplr  <= b;
            count <= '0;
        end else if (run) begin
            acc   <= product;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Registered-output ALU with start/busy/done handshake and NZCV flags.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, sampled only in IDLE
//   alu_control : opcode (alu_op_e), latched with start
//   src_a/src_b : operands, latched with start
//   set_flags   : update flags on completion of this request
//   busy        : high while a MUL iterates
//   done        : one-cycle pulse, result (and flags if requested) valid
//   result      : registered result, held until next completion
//   flags       : registered {V,C,N,Z}, held until next flag-writing completion
// Non-MUL ops complete on the start edge; MUL takes WIDTH further edges.
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             set_flags,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int SW = $clog2(WIDTH);

    state_e             state, next_state;
    alu_op_e            op;
    logic               set_flags_q;
    logic               accept;
    logic               mul_load;
    logic [2*WIDTH-1:0] mul_product;
    logic               mul_last;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic [SW-1:0]      shamt;
    logic [WIDTH:0]     wide;

    logic [WIDTH-1:0]   result_d;
    logic [3:0]         flags_d;
    logic               done_d;

    assign op       = alu_op_e'(alu_control);
    assign accept   = (state == ST_IDLE) && start;
    assign mul_load = accept && (op == OP_MUL) && MUL_EN;
    assign shamt    = src_b[SW-1:0];

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (mul_load),
                .run     (state == ST_MUL),
                .a       (src_a),
                .b       (src_b),
                .product (mul_product),
                .last    (mul_last)
            );
        end else begin : g_no_mul
            assign mul_product = '0;
            assign mul_last    = 1'b0;
        end
    endgenerate

    // Single-cycle datapath for everything except an enabled MUL.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        wide    = '0;
        unique case (op)
            OP_ADD: begin
                wide    = {1'b0, src_a} + {1'b0, src_b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                wide    = {1'b0, src_a} - {1'b0, src_b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = ~wide[WIDTH];            // carry = no borrow
                alu_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND: alu_res = src_a & src_b;
            OP_OR:  alu_res = src_a | src_b;
            OP_XOR: alu_res = src_a ^ src_b;
            OP_LSL: begin
                // Extra top bit catches the last bit shifted out (0 for amount 0).
                wide    = {1'b0, src_a} << shamt;
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_LSR: begin
                // Extra bottom bit catches the last bit shifted out.
                wide    = {src_a, 1'b0} >> shamt;
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            OP_MUL: begin
                // Only reached as a single-cycle op when MUL is not built:
                // result 0, so Z=1 and everything else clear.
                alu_res = '0;
            end
            default: alu_res = '0;
        endcase
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // ---- FSM: next-state logic ----
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (mul_load) next_state = ST_MUL;
            ST_MUL:  if (mul_last) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // ---- FSM: output logic (next values of the registered outputs) ----
    always_comb begin
        result_d = result;
        flags_d  = flags;
        done_d   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept && !mul_load) begin
                    result_d = alu_res;
                    done_d   = 1'b1;
                    if (set_flags) begin
                        flags_d[FLAG_Z] = (alu_res == '0);
                        flags_d[FLAG_N] = alu_res[WIDTH-1];
                        flags_d[FLAG_C] = alu_c;
                        flags_d[FLAG_V] = alu_v;
                    end
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    result_d = mul_product[WIDTH-1:0];
                    done_d   = 1'b1;
                    if (set_flags_q) begin
                        flags_d[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
                        flags_d[FLAG_N] = mul_product[WIDTH-1];
                        flags_d[FLAG_C] = (mul_product[2*WIDTH-1:WIDTH] != '0);
                        flags_d[FLAG_V] = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result      <= '0;
            flags       <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            set_flags_q <= 1'b0;
        end else begin
            result <= result_d;
            flags  <= flags_d;
            done   <= done_d;
            busy   <= (next_state == ST_MUL);
            if (mul_load) set_flags_q <= set_flags;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed self-checking bench for alu_seq at WIDTH=16, MUL_EN=1.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             set_flags;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    int tests_run  = 0;
    int fail_count = 0;

    alu_seq #(.WIDTH(WIDTH), .MUL_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .set_flags   (set_flags),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .flags       (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic sf);
        start       = 1'b1;
        alu_control = op;
        src_a       = a;
        src_b       = b;
        set_flags   = sf;
    endtask

    // Runs edges 2..16 of a MUL (start was sampled at edge 1), counting any
    // premature done or dropped busy; optionally injects an ADD start mid-run.
    task automatic mul_body(input bit inject, output int early_done,
                            output int busy_low);
        early_done = 0;
        busy_low   = 0;
        for (int e = 2; e <= 16; e++) begin
            tick();
            if (done)  early_done++;
            if (!busy) busy_low++;
            if (inject && e == 5) drive(3'b000, 16'h0001, 16'h0001, 1'b1);
            if (inject && e == 6) start = 1'b0;
        end
    endtask

    int early_done, busy_low;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        alu_control = '0;
        src_a = '0;
        src_b = '0;
        set_flags = 1'b0;
        #12;
        check("reset_busy",   busy,   0);
        check("reset_done",   done,   0);
        check("reset_result", result, 0);
        check("reset_flags",  flags,  0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ADD overflow into sign bit: V and N set, latency 1, no busy.
        drive(3'b000, 16'h7FFF, 16'h0001, 1'b1);
        tick();
        check("add_done",   done,   1);
        check("add_busy",   busy,   0);
        check("add_result", result, 16'h8000);
        check("add_flags",  flags,  4'b1010);

        // Back-to-back SUBs: equal operands, then borrow.
        drive(3'b001, 16'h0005, 16'h0005, 1'b1);
        tick();
        check("sub0_done",   done,   1);
        check("sub0_result", result, 16'h0000);
        check("sub0_flags",  flags,  4'b0101);
        drive(3'b001, 16'h0003, 16'h0005, 1'b1);
        tick();
        check("sub1_done",   done,   1);
        check("sub1_result", result, 16'hFFFE);
        check("sub1_flags",  flags,  4'b0010);
        start = 1'b0;
        tick();
        check("idle_done", done, 0);

        // Shifts: only the low log2(WIDTH) bits of src_b count.
        drive(3'b101, 16'h8001, 16'h0011, 1'b1);
        tick();
        check("lsl_result", result, 16'h0002);
        check("lsl_flags",  flags,  4'b0100);
        drive(3'b110, 16'h0001, 16'h0000, 1'b1);
        tick();
        check("lsr_result", result, 16'h0001);
        check("lsr_flags",  flags,  4'b0000);

        // XOR with a sign-bit result.
        drive(3'b100, 16'hFF00, 16'h0F0F, 1'b1);
        tick();
        check("xor_result", result, 16'hF00F);
        check("xor_flags",  flags,  4'b0010);

        // MUL 0x100*0x100 = 0x10000: low half zero, high half nonzero.
        drive(3'b111, 16'h0100, 16'h0100, 1'b1);
        tick();
        check("mul_busy_e1", busy, 1);
        check("mul_done_e1", done, 0);
        start = 1'b0;
        mul_body(1'b1, early_done, busy_low);
        check("mul_early_done", 32'(early_done), 0);
        check("mul_busy_low",   32'(busy_low),   0);
        tick();
        check("mul_done_e17", done,   1);
        check("mul_busy_e17", busy,   0);
        check("mul_result",   result, 16'h0000);
        check("mul_flags",    flags,  4'b0101);
        tick();
        check("mul_after_done",   done,   0);
        check("mul_after_result", result, 16'h0000);

        // AND without flag update keeps previous flags.
        drive(3'b010, 16'hF0F0, 16'h0F0F, 1'b0);
        tick();
        check("and_done",   done,   1);
        check("and_result", result, 16'h0000);
        check("and_flags",  flags,  4'b0101);

        // Give result/flags nonzero values before the reset test.
        drive(3'b001, 16'h0003, 16'h0005, 1'b1);
        tick();
        check("pre_rst_result", result, 16'hFFFE);

        // MUL aborted by asynchronous reset after edge 8.
        drive(3'b111, 16'h0003, 16'h0004, 1'b1);
        tick();
        start = 1'b0;
        for (int e = 2; e <= 8; e++) tick();
        check("mid_mul_busy", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy",   busy,   0);
        check("arst_done",   done,   0);
        check("arst_result", result, 0);
        check("arst_flags",  flags,  0);
        tick();
        tick();
        check("arst_hold_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full MUL after reset release.
        drive(3'b111, 16'h0003, 16'h0004, 1'b1);
        tick();
        start = 1'b0;
        mul_body(1'b0, early_done, busy_low);
        check("mul2_early_done", 32'(early_done), 0);
        tick();
        check("mul2_done",   done,   1);
        check("mul2_result", result, 16'h000C);
        check("mul2_flags",  flags,  4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
